// File: rtl/ram_port_arbiter_pkg.sv
// ============================================================================
//  Module      : ram_port_arbiter_pkg
//  Description : Shared definitions for the two-port RAM arbiter. Holds the
//                default RAM geometry, the requester ID encoding and the tag
//                carried down the read-response pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    // Requester identifiers as carried in the response pipe and pointer
    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    // One slot of the read-response pipe
    typedef struct packed {
        logic valid;
        logic id;
    } rsp_tag_t;

endpackage

`default_nettype wire

// File: rtl/ram_port_arbiter_rr_arb2.sv
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-input round-robin grant with bounded lock hold.
//                Ports:
//                  clk, rst          - clock, synchronous active-high reset
//                  req_a/req_b       - requests
//                  lock_a/lock_b     - burst lock requests
//                  gnt_a/gnt_b       - combinational one-hot grants
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
    import ram_port_arbiter_pkg::*;
#(
    parameter int MAX_LOCK = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic lock_a,
    input  logic lock_b,
    output logic gnt_a,
    output logic gnt_b
);

    localparam int              CNT_W = 4;
    localparam logic [CNT_W-1:0] c_max_lock = CNT_W'(MAX_LOCK);

    logic             r_ptr;        // ID that wins a tie
    logic             r_own_vld;    // an owner has been recorded since reset
    logic             r_own_id;     // ID of last accepted requester
    logic [CNT_W-1:0] r_lock_cnt;   // contended grants held under lock

    logic             w_acc;
    logic             w_id;
    logic             w_lock;
    logic             w_other_req;
    logic             w_own_lock;
    logic [CNT_W-1:0] w_base;
    logic [CNT_W-1:0] w_cnt_inc;

    // A is granted unless B also requests and B holds the pointer
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!rst) begin
            if (req_a && !(req_b && (r_ptr == ID_B))) begin
                gnt_a = 1'b1;
            end else if (req_b) begin
                gnt_b = 1'b1;
            end
        end
    end

    // Grants are only ever raised alongside their request
    assign w_acc       = gnt_a | gnt_b;
    assign w_id        = gnt_b ? ID_B : ID_A;
    assign w_lock      = gnt_b ? lock_b : lock_a;
    assign w_other_req = gnt_b ? req_a : req_b;
    assign w_own_lock  = (r_own_id == ID_B) ? lock_b : lock_a;

    // Count restarts whenever ownership moves to the other requester
    assign w_base    = (r_own_vld && (r_own_id == w_id)) ? r_lock_cnt : '0;
    assign w_cnt_inc = w_base + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= ID_A;
            r_own_vld  <= 1'b0;
            r_own_id   <= ID_A;
            r_lock_cnt <= '0;
        end else if (w_acc) begin
            r_own_vld <= 1'b1;
            r_own_id  <= w_id;
            if (!w_lock) begin
                r_lock_cnt <= '0;
                r_ptr      <= ~w_id;
            end else if (w_other_req) begin
                // Budget exhausted: hand the next tie to the waiting side
                if (w_cnt_inc >= c_max_lock) begin
                    r_lock_cnt <= '0;
                    r_ptr      <= ~w_id;
                end else begin
                    r_lock_cnt <= w_cnt_inc;
                    r_ptr      <= w_id;
                end
            end else begin
                // Uncontended locked access never consumes lock budget
                r_lock_cnt <= w_base;
                r_ptr      <= w_id;
            end
        end else if (r_own_vld && !w_own_lock) begin
            r_lock_cnt <= '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ============================================================================
//  Module      : ram_port_arbiter
//  Description : Shares one single-port RAM between requesters A and B.
//                Ports:
//                  clk, rst                 - clock, sync active-high reset
//                  req/we/lock/addr/wdata_x - requester command inputs
//                  gnt_x                    - combinational grant
//                  rd_valid_x, rd_data_x    - registered read response
//                  ram_en/we/addr/wr_data   - registered RAM command
//                  ram_rd_data              - RAM read data
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic              lock_a,
    input  logic              lock_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rd_valid_a,
    output logic              rd_valid_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data
);

    logic              w_acc;
    logic              w_id;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    rsp_tag_t          w_tail;

    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wr_data;
    rsp_tag_t [RD_LAT:0] r_pipe;
    logic              r_rd_valid_a;
    logic              r_rd_valid_b;
    logic [DATA_W-1:0] r_rd_data_a;
    logic [DATA_W-1:0] r_rd_data_b;

    rr_arb2 #(
        .MAX_LOCK (MAX_LOCK)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req_a  (req_a),
        .req_b  (req_b),
        .lock_a (lock_a),
        .lock_b (lock_b),
        .gnt_a  (gnt_a),
        .gnt_b  (gnt_b)
    );

    // Select the command of whichever port wins this cycle
    assign w_acc   = gnt_a | gnt_b;
    assign w_id    = gnt_b ? ID_B : ID_A;
    assign w_we    = gnt_b ? we_b : we_a;
    assign w_addr  = gnt_b ? addr_b : addr_a;
    assign w_wdata = gnt_b ? wdata_b : wdata_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ram_en      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_wr_data <= '0;
        end else if (w_acc) begin
            r_ram_en      <= 1'b1;
            r_ram_we      <= w_we;
            r_ram_addr    <= w_addr;
            r_ram_wr_data <= w_wdata;
        end else begin
            // Address and data hold so the RAM pins stay quiet when idle
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
        end
    end

    // Slot 0 is loaded on the accept edge; the tail lines up with the
    // cycle in which ram_rd_data carries the matching word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= '{valid: w_acc && !w_we, id: w_id};
            for (int i = 1; i <= RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_tail = r_pipe[RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid_a <= 1'b0;
            r_rd_valid_b <= 1'b0;
            r_rd_data_a  <= '0;
            r_rd_data_b  <= '0;
        end else begin
            r_rd_valid_a <= w_tail.valid && (w_tail.id == ID_A);
            r_rd_valid_b <= w_tail.valid && (w_tail.id == ID_B);
            if (w_tail.valid && (w_tail.id == ID_A)) begin
                r_rd_data_a <= ram_rd_data;
            end
            if (w_tail.valid && (w_tail.id == ID_B)) begin
                r_rd_data_b <= ram_rd_data;
            end
        end
    end

    assign ram_en      = r_ram_en;
    assign ram_we      = r_ram_we;
    assign ram_addr    = r_ram_addr;
    assign ram_wr_data = r_ram_wr_data;
    assign rd_valid_a  = r_rd_valid_a;
    assign rd_valid_b  = r_rd_valid_b;
    assign rd_data_a   = r_rd_data_a;
    assign rd_data_b   = r_rd_data_b;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
//  Module      : tb_ram_port_arbiter
//  Description : Self-checking bench for ram_port_arbiter with a behavioural
//                32x8 RAM (one-cycle registered read).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, req_b, we_a, we_b, lock_a, lock_b;
    logic [4:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       gnt_a, gnt_b, rd_valid_a, rd_valid_b;
    logic [7:0] rd_data_a, rd_data_b;
    logic       ram_en, ram_we;
    logic [4:0] ram_addr;
    logic [7:0] ram_wr_data, ram_rd_data;

    logic [7:0] mem [32];
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .ADDR_W   (5),
        .DATA_W   (8),
        .RD_LAT   (1),
        .MAX_LOCK (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_a       (req_a),
        .req_b       (req_b),
        .we_a        (we_a),
        .we_b        (we_b),
        .lock_a      (lock_a),
        .lock_b      (lock_b),
        .addr_a      (addr_a),
        .addr_b      (addr_b),
        .wdata_a     (wdata_a),
        .wdata_b     (wdata_b),
        .gnt_a       (gnt_a),
        .gnt_b       (gnt_b),
        .rd_valid_a  (rd_valid_a),
        .rd_valid_b  (rd_valid_b),
        .rd_data_a   (rd_data_a),
        .rd_data_b   (rd_data_b),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data)
    );

    // Behavioural RAM: read data valid the cycle after the command edge
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wr_data;
            else        ram_rd_data   <= mem[ram_addr];
        end
    end

    typedef struct {
        logic       ra, wa, la; logic [4:0] aa; logic [7:0] da;
        logic       rb, wb, lb; logic [4:0] ab; logic [7:0] db;
        logic       ga, gb, en, we; logic [4:0] addr; logic [7:0] wd;
        logic       va, vb; logic [7:0] rda, rdb;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        req_a = 0; we_a = 0; lock_a = 0; addr_a = 0; wdata_a = 0;
        req_b = 0; we_b = 0; lock_b = 0; addr_b = 0; wdata_b = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        ram_rd_data = 8'h00;

        //            ra wa la aa  da     rb wb lb ab  db     ga gb en we addr wd     va vb rda    rdb
        vecs[0]  = '{1, 1, 0, 3,  8'h33, 0, 0, 0, 0,  8'h00, 1, 0, 1, 1, 3,  8'h33, 0, 0, 8'h00, 8'h00};
        vecs[1]  = '{0, 0, 0, 0,  8'h00, 1, 1, 0, 31, 8'h5A, 0, 1, 1, 1, 31, 8'h5A, 0, 0, 8'h00, 8'h00};
        vecs[2]  = '{1, 0, 0, 3,  8'h00, 1, 0, 0, 31, 8'h00, 1, 0, 1, 0, 3,  8'h00, 0, 0, 8'h00, 8'h00};
        vecs[3]  = '{1, 0, 0, 3,  8'h00, 1, 0, 0, 31, 8'h00, 0, 1, 1, 0, 31, 8'h00, 0, 0, 8'h00, 8'h00};
        vecs[4]  = '{0, 0, 0, 0,  8'h00, 0, 0, 0, 0,  8'h00, 0, 0, 0, 0, 31, 8'h00, 1, 0, 8'h33, 8'h00};
        vecs[5]  = '{0, 0, 0, 0,  8'h00, 0, 0, 0, 0,  8'h00, 0, 0, 0, 0, 31, 8'h00, 0, 1, 8'h00, 8'h5A};
        vecs[6]  = '{0, 0, 0, 0,  8'h00, 0, 0, 0, 0,  8'h00, 0, 0, 0, 0, 31, 8'h00, 0, 0, 8'h00, 8'h00};
        vecs[7]  = '{1, 0, 0, 31, 8'h00, 1, 0, 0, 3,  8'h00, 1, 0, 1, 0, 31, 8'h00, 0, 0, 8'h00, 8'h00};
        vecs[8]  = '{0, 0, 0, 0,  8'h00, 0, 0, 0, 0,  8'h00, 0, 0, 0, 0, 31, 8'h00, 0, 0, 8'h00, 8'h00};
        vecs[9]  = '{1, 0, 0, 0,  8'h00, 1, 0, 0, 3,  8'h00, 0, 1, 1, 0, 3,  8'h00, 1, 0, 8'h5A, 8'h00};
        vecs[10] = '{0, 0, 0, 0,  8'h00, 0, 0, 0, 0,  8'h00, 0, 0, 0, 0, 3,  8'h00, 0, 0, 8'h00, 8'h00};
        vecs[11] = '{0, 0, 0, 0,  8'h00, 0, 0, 0, 0,  8'h00, 0, 0, 0, 0, 3,  8'h00, 0, 1, 8'h00, 8'h33};
        vecs[12] = '{1, 1, 0, 7,  8'hC3, 0, 0, 0, 0,  8'h00, 1, 0, 1, 1, 7,  8'hC3, 0, 0, 8'h00, 8'h00};
        vecs[13] = '{1, 0, 0, 7,  8'h00, 0, 0, 0, 0,  8'h00, 1, 0, 1, 0, 7,  8'h00, 0, 0, 8'h00, 8'h00};
        vecs[14] = '{0, 0, 0, 0,  8'h00, 0, 0, 0, 0,  8'h00, 0, 0, 0, 0, 7,  8'h00, 0, 0, 8'h00, 8'h00};
        vecs[15] = '{0, 0, 0, 0,  8'h00, 0, 0, 0, 0,  8'h00, 0, 0, 0, 0, 7,  8'h00, 1, 0, 8'hC3, 8'h00};

        // ---------------- reset state, grants gated while rst high -------
        idle();
        rst = 1;
        req_a = 1; req_b = 1;
        #1;
        chk("rst_gnt_a", gnt_a, 0);
        chk("rst_gnt_b", gnt_b, 0);
        tick();
        tick();
        chk("rst_ram_en", ram_en, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wr_data", ram_wr_data, 0);
        chk("rst_rd_valid", {rd_valid_a, rd_valid_b}, 0);
        chk("rst_rd_data", {rd_data_a, rd_data_b}, 0);
        idle();
        rst = 0;

        // ---------------- table-driven vectors ---------------------------
        for (int i = 0; i < 16; i++) begin
            req_a = vecs[i].ra; we_a = vecs[i].wa; lock_a = vecs[i].la;
            addr_a = vecs[i].aa; wdata_a = vecs[i].da;
            req_b = vecs[i].rb; we_b = vecs[i].wb; lock_b = vecs[i].lb;
            addr_b = vecs[i].ab; wdata_b = vecs[i].db;
            #1;
            chk($sformatf("v%0d_gnt", i), {gnt_a, gnt_b}, {vecs[i].ga, vecs[i].gb});
            tick();
            chk($sformatf("v%0d_en_we", i), {ram_en, ram_we}, {vecs[i].en, vecs[i].we});
            chk($sformatf("v%0d_addr", i), ram_addr, vecs[i].addr);
            chk($sformatf("v%0d_wdata", i), ram_wr_data, vecs[i].wd);
            chk($sformatf("v%0d_rd_valid", i), {rd_valid_a, rd_valid_b}, {vecs[i].va, vecs[i].vb});
            if (vecs[i].va) chk($sformatf("v%0d_rd_data_a", i), rd_data_a, vecs[i].rda);
            if (vecs[i].vb) chk($sformatf("v%0d_rd_data_b", i), rd_data_b, vecs[i].rdb);
        end

        // ---------------- A writes 0..31 back to back --------------------
        for (int i = 0; i < 32; i++) begin
            req_a = 1; we_a = 1; addr_a = 5'(i); wdata_a = 8'(i + 1);
            #1;
            chk($sformatf("fill%0d_gnt", i), {gnt_a, gnt_b}, 2'b10);
            tick();
            chk($sformatf("fill%0d_cmd", i), {ram_en, ram_we, ram_addr, ram_wr_data},
                {1'b1, 1'b1, 5'(i), 8'(i + 1)});
        end

        // ---------------- read latency: addr 5 holds 0x06 ----------------
        idle();
        req_a = 1; addr_a = 5;
        #1;
        chk("lat_gnt_a", gnt_a, 1);
        tick();
        idle();
        chk("lat_valid_e0", {rd_valid_a, rd_valid_b}, 2'b00);
        tick();
        chk("lat_valid_e1", {rd_valid_a, rd_valid_b}, 2'b00);
        tick();
        chk("lat_valid_e2", {rd_valid_a, rd_valid_b}, 2'b10);
        chk("lat_data", rd_data_a, 8'h06);
        tick();
        chk("lat_valid_e3", {rd_valid_a, rd_valid_b}, 2'b00);

        // ---------------- contention: alternate A,B from reset -----------
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                req_a = 1; addr_a = 10; req_b = 1; addr_b = 20;
            end else begin
                idle();
            end
            #1;
            if (k < 6) chk($sformatf("cont%0d_gnt", k), {gnt_a, gnt_b}, (k % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            if (k >= 2) begin
                chk($sformatf("cont%0d_valid", k), {rd_valid_a, rd_valid_b},
                    ((k - 2) % 2 == 0) ? 2'b10 : 2'b01);
                if ((k - 2) % 2 == 0) chk($sformatf("cont%0d_data_a", k), rd_data_a, 8'h0B);
                else                  chk($sformatf("cont%0d_data_b", k), rd_data_b, 8'h15);
            end
        end

        // ---------------- lock: 8 A grants, one B, A resumes -------------
        do_reset();
        for (int k = 0; k < 10; k++) begin
            req_a = 1; lock_a = 1; addr_a = 1; req_b = 1; addr_b = 2;
            #1;
            chk($sformatf("lock%0d_gnt", k), {gnt_a, gnt_b}, (k == 8) ? 2'b01 : 2'b10);
            tick();
        end
        req_b = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk($sformatf("lock_solo%0d_gnt", k), {gnt_a, gnt_b}, 2'b10);
            tick();
        end
        idle();
        tick();
        tick();

        // ---------------- reset one cycle after an accepted read ---------
        req_a = 1; addr_a = 5;
        #1;
        chk("rmr_gnt_a", gnt_a, 1);
        tick();
        idle();
        rst = 1;
        tick();
        chk("rmr_cmd", {ram_en, ram_we, ram_addr, ram_wr_data}, 0);
        chk("rmr_valid0", {rd_valid_a, rd_valid_b}, 0);
        chk("rmr_data", {rd_data_a, rd_data_b}, 0);
        rst = 0;
        tick();
        chk("rmr_valid1", {rd_valid_a, rd_valid_b}, 0);
        tick();
        chk("rmr_valid2", {rd_valid_a, rd_valid_b}, 0);
        req_a = 1; req_b = 1;
        #1;
        chk("rmr_ptr_a", {gnt_a, gnt_b}, 2'b10);
        tick();
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
